// File: rtl/bus_cycle_master.sv
// Initiator for the 8-bit CS_n/RD_n/WR_n peripheral bus with programmable setup/strobe/hold.
// Optional peripheral wait-state support is enabled by defining BUS_WAIT_EN.
module bus_cycle_master #(
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] A,
  output logic              CS_n,
  output logic              RD_n,
  output logic              WR_n,
  inout  wire  [7:0]        DataBus
`ifdef BUS_WAIT_EN
  ,
  input  logic              WAIT
`endif
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StStrobe = 2'd2;
  localparam logic [1:0] StHold   = 2'd3;

  localparam logic [3:0] SetupLd  = 4'(SETUP_CYC);
  localparam logic [3:0] StrobeLd = 4'(STROBE_CYC);
  localparam logic [3:0] HoldLd   = 4'(HOLD_CYC);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q;
  logic              done_q, done_d;
  logic              cs_n_q, rd_n_q, wr_n_q, drive_q;
  logic              capture;
  logic              stall;

`ifdef BUS_WAIT_EN
  assign stall = WAIT;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StSetup;
          cnt_d   = SetupLd;
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
        end
      end
      StSetup: begin
        if (cnt_q == 4'd1) begin
          state_d = StStrobe;
          cnt_d   = StrobeLd;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StStrobe: begin
        // The last strobe cycle repeats while the peripheral asserts wait.
        if (cnt_q == 4'd1) begin
          if (!stall) begin
            state_d = StHold;
            cnt_d   = HoldLd;
            capture = !we_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (cnt_q == 4'd1) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus pins are registered from the next state so they change together with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      done_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      cs_n_q  <= (state_d == StIdle);
      rd_n_q  <= !((state_d == StStrobe) && !we_d);
      wr_n_q  <= !((state_d == StStrobe) && we_d);
      drive_q <= (state_d != StIdle) && we_d;
      if (capture) begin
        rdata_q <= DataBus;
      end
    end
  end

  assign ready   = (state_q == StIdle);
  assign busy    = !ready;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign A       = addr_q;
  assign CS_n    = cs_n_q;
  assign RD_n    = rd_n_q;
  assign WR_n    = wr_n_q;
  assign DataBus = drive_q ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_bus_cycle_master.sv
// Directed bench for bus_cycle_master: table of transfers plus reset and busy-request sequences.
// Define BUS_WAIT_EN for both files to include the wait-state vector.
module tb_bus_cycle_master;

  localparam int S = 1;
  localparam int P = 2;
  localparam int H = 1;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] pval;
    int         waits;
    bit         b2b;
    bit         poke;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = 2'b00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] pval = 8'h00;
  logic       ready, busy, done, CS_n, RD_n, WR_n;
  logic [7:0] rdata;
  logic [1:0] A;
  tri   [7:0] DataBus;
`ifdef BUS_WAIT_EN
  logic       WAIT = 1'b0;
`endif

  // Peripheral model drives the bus only while the read strobe is low.
  assign DataBus = RD_n ? 8'hzz : pval;

  bus_cycle_master #(
    .ADDR_W    (2),
    .SETUP_CYC (S),
    .STROBE_CYC(P),
    .HOLD_CYC  (H)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .rdata  (rdata),
    .A      (A),
    .CS_n   (CS_n),
    .RD_n   (RD_n),
    .WR_n   (WR_n),
    .DataBus(DataBus)
`ifdef BUS_WAIT_EN
    ,
    .WAIT   (WAIT)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passes = 0;
  logic [7:0] exp_rdata = 8'h00;
  vec_t       tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // An undriven bus reads as z in event simulators and as 0 in two-state ones.
  task automatic chk_float(input string name);
    logic ok;
    ok = (DataBus === 8'hzz) || (DataBus === 8'h00);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: bus driven with %h, required high-Z", name, DataBus);
  endtask

  task automatic xfer(input vec_t v, input bit pre, input bit chain, input vec_t nv);
    int         total;
    int         n;
    bit         stb;
    logic       cs_e, rd_e, wr_e, done_e;
    total = S + P + v.waits + H;
    if (!pre) begin
      n = 0;
      while (!ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("ready_before_req", {31'd0, ready}, 32'd1);
      req   = 1'b1;
      we    = v.we;
      addr  = v.addr;
      wdata = v.wdata;
    end
    pval = v.pval;
    @(posedge clk);
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      cs_e   = (c <= total) ? 1'b0 : 1'b1;
      stb    = (c >= S + 1) && (c <= S + P + v.waits);
      rd_e   = !(stb && !v.we);
      wr_e   = !(stb && v.we);
      done_e = (c == total + 1);
      chk($sformatf("ctl c%0d {cs,rd,wr,done,ready,busy}", c),
          {26'd0, CS_n, RD_n, WR_n, done, ready, busy},
          {26'd0, cs_e, rd_e, wr_e, done_e, done_e, !done_e});
      if (v.we && c <= total) chk($sformatf("wbus c%0d", c), {24'd0, DataBus}, {24'd0, v.wdata});
      else if (!v.we && stb) chk($sformatf("rbus c%0d", c), {24'd0, DataBus}, {24'd0, v.pval});
      else chk_float($sformatf("float c%0d", c));
      if (c <= total) chk($sformatf("addr c%0d", c), {30'd0, A}, {30'd0, v.addr});
      if (done_e) begin
        if (!v.we) exp_rdata = v.pval;
        chk("rdata", {24'd0, rdata}, {24'd0, exp_rdata});
      end
      // Drop the request and disturb the inputs; the latched copy must be used.
      if (c == 1) begin
        req   = 1'b0;
        we    = ~v.we;
        addr  = ~v.addr;
        wdata = ~v.wdata;
      end
      if (v.poke && c == S + 1) req = 1'b1;
      if (v.poke && c == S + 2) req = 1'b0;
`ifdef BUS_WAIT_EN
      WAIT = (c >= S + P) && (c < S + P + v.waits);
`endif
      if (done_e && chain) begin
        req   = 1'b1;
        we    = nv.we;
        addr  = nv.addr;
        wdata = nv.wdata;
      end
    end
  endtask

  initial begin
    int extra;
    vec_t none;
    none = '{1'b0, 2'b00, 8'h00, 8'h00, 0, 1'b0, 1'b0};
    tv.push_back('{1'b1, 2'b01, 8'hA5, 8'h00, 0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 2'b10, 8'h81, 8'h3C, 0, 1'b0, 1'b0});
    tv.push_back('{1'b1, 2'b11, 8'hC3, 8'h00, 0, 1'b1, 1'b0});
    tv.push_back('{1'b0, 2'b00, 8'hF0, 8'h5E, 0, 1'b1, 1'b0});
    tv.push_back('{1'b1, 2'b10, 8'hFF, 8'h00, 0, 1'b0, 1'b0});
    tv.push_back('{1'b1, 2'b00, 8'h77, 8'h00, 0, 1'b0, 1'b1});
`ifdef BUS_WAIT_EN
    tv.push_back('{1'b0, 2'b01, 8'h42, 8'h96, 3, 1'b0, 1'b0});
`endif

    #12;
    chk("reset {cs,rd,wr,done,ready,busy}", {26'd0, CS_n, RD_n, WR_n, done, ready, busy},
        32'b111010);
    chk("reset rdata", {24'd0, rdata}, 32'h00);
    chk("reset addr", {30'd0, A}, 32'd0);
    chk_float("reset bus");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      xfer(tv[i], (i > 0) && tv[i-1].b2b, tv[i].b2b && (i + 1 < tv.size()),
           (i + 1 < tv.size()) ? tv[i+1] : none);
      if (tv[i].poke) begin
        extra = 0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (done || !CS_n) extra++;
        end
        chk("ignored busy req", extra, 0);
      end
    end

    // Reset in cycle 2 of a write.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 2'b10; wdata = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("pre-reset write drive", {24'd0, DataBus}, 32'h5A);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst {cs,rd,wr,done,ready,busy}", {26'd0, CS_n, RD_n, WR_n, done, ready, busy},
        32'b111010);
    chk_float("midrst bus");
    exp_rdata = 8'h00;
    chk("midrst rdata", {24'd0, rdata}, 32'h00);
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("no done under reset", extra, 0);
    rst = 1'b1;
    xfer('{1'b0, 2'b11, 8'h18, 8'hC6, 0, 1'b0, 1'b0}, 1'b0, 1'b0, none);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
